// File: rtl/wb_trap_unit.sv
// wb_trap_unit -- write-back and trap stage at the end of the pipeline.
//
// Purpose:
//   Commits register-file write-back for retiring instructions. Encodes
//   prioritised synchronous exceptions together with synchronised external
//   and local interrupts, and issues a registered trap or MRET redirect.
//   After every redirect it runs a counted pipeline-flush sequence.
//
// Ports:
//   clk_i, rst_i           clock (rising edge), asynchronous active-low reset
//   valid_i, pc_i,
//   instruction_i          instruction presented by the MEM stage
//   alu_d_i, mem_d_i,
//   csr_rdata_i            write-back data sources
//   mem_addr_i             load/store effective address (mtval on misalign)
//   mtvec_i, mepc_i        trap vector (direct mode) and MRET return address
//   mstatus_mie_i, mie_i   global and per-cause interrupt enables
//   xint_*_i, lirq_i       asynchronous interrupt levels
//   e_*_i                  exception flags from earlier stages
//   rd_o, rf_wd_o, we_rf_o register-file write port
//   trap_we_o, mcause_o,
//   mepc_o, mtval_o        CSR trap-update bus
//   mret_o                 MRET strobe to the CSR file
//   redirect_o,
//   redirect_pc_o          fetch redirect pulse and target
//   flush_o, ready_o       kill younger instructions / upstream may advance
//   retired_o              instruction committed
module wb_trap_unit #(
  parameter int XLEN         = 32,
  parameter int NUM_LIRQ     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [31:0]            instruction_i,
  input  logic [XLEN-1:0]        alu_d_i,
  input  logic [XLEN-1:0]        mem_d_i,
  input  logic [XLEN-1:0]        csr_rdata_i,
  input  logic [XLEN-1:0]        mem_addr_i,
  input  logic [XLEN-1:0]        mtvec_i,
  input  logic [XLEN-1:0]        mepc_i,
  input  logic                   mstatus_mie_i,
  input  logic [15+NUM_LIRQ:0]   mie_i,
  input  logic                   xint_meip_i,
  input  logic                   xint_mtip_i,
  input  logic                   xint_msip_i,
  input  logic [NUM_LIRQ-1:0]    lirq_i,
  input  logic                   e_illegal_inst_i,
  input  logic                   e_inst_addr_mis_i,
  input  logic                   e_ld_addr_mis_i,
  input  logic                   e_st_addr_mis_i,
  output logic [4:0]             rd_o,
  output logic [XLEN-1:0]        rf_wd_o,
  output logic                   we_rf_o,
  output logic                   trap_we_o,
  output logic [XLEN-1:0]        mcause_o,
  output logic [XLEN-1:0]        mepc_o,
  output logic [XLEN-1:0]        mtval_o,
  output logic                   mret_o,
  output logic                   redirect_o,
  output logic [XLEN-1:0]        redirect_pc_o,
  output logic                   flush_o,
  output logic                   ready_o,
  output logic                   retired_o
);

  localparam int NIRQ = 3 + NUM_LIRQ;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPI    = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_flush_cnt, w_cnt_nxt;
  logic [NIRQ-1:0]   r_sync [SYNC_STAGES];

  logic [NIRQ-1:0]     w_irq;
  logic                w_mei, w_msi, w_mti;
  logic [NUM_LIRQ-1:0] w_lirq;
  logic [4:0]          w_lirq_idx;
  logic [6:0]          w_opcode;
  logic [2:0]          w_funct3;
  logic [4:0]          w_rd;
  logic                w_ecall, w_ebreak, w_mret, w_illegal;
  logic                w_trap, w_intr;
  logic [4:0]          w_code;
  logic [XLEN-1:0]     w_tval, w_mcause;
  logic                w_wb_en;
  logic [XLEN-1:0]     w_wb_data;
  logic                w_unused;

  logic [4:0]      w_rd_nxt;
  logic [XLEN-1:0] w_wd_nxt, w_mcause_nxt, w_mepc_nxt, w_mtval_nxt, w_rpc_nxt;
  logic            w_we_nxt, w_trap_we_nxt, w_mret_nxt, w_redir_nxt, w_retired_nxt;

  // Synchroniser chains for every asynchronous interrupt level
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= {NIRQ{1'b0}};
    end else begin
      r_sync[0] <= {lirq_i, xint_mtip_i, xint_msip_i, xint_meip_i};
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  // Bit order of the synchronised vector: 0 MEI, 1 MSI, 2 MTI, 3+i LIRQ i
  assign w_irq  = r_sync[SYNC_STAGES-1];
  assign w_mei  = w_irq[0] & mie_i[11] & mstatus_mie_i;
  assign w_msi  = w_irq[1] & mie_i[3]  & mstatus_mie_i;
  assign w_mti  = w_irq[2] & mie_i[7]  & mstatus_mie_i;
  assign w_lirq = w_irq[NIRQ-1:3] & mie_i[15+NUM_LIRQ:16] & {NUM_LIRQ{mstatus_mie_i}};

  // Enable bits with no interrupt source behind them
  assign w_unused = ^{mie_i[15:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

  // Lowest-numbered pending local interrupt; scanning downward lets the lowest index win
  always_comb begin
    w_lirq_idx = 5'd0;
    for (int i = NUM_LIRQ - 1; i >= 0; i--) begin
      w_lirq_idx = w_lirq[i] ? 5'(i) : w_lirq_idx;
    end
  end

  assign w_opcode  = instruction_i[6:0];
  assign w_funct3  = instruction_i[14:12];
  assign w_rd      = instruction_i[11:7];
  assign w_ecall   = (instruction_i == 32'h0000_0073);
  assign w_ebreak  = (instruction_i == 32'h0010_0073);
  assign w_mret    = (instruction_i == 32'h3020_0073);
  // URET and SRET do not exist on this machine-only core
  assign w_illegal = e_illegal_inst_i | (instruction_i == 32'h0020_0073)
                   | (instruction_i == 32'h1020_0073);

  // Prioritised trap cause and trap value; interrupts outrank all exceptions
  always_comb begin
    w_trap = 1'b1;
    w_intr = 1'b0;
    w_code = 5'd0;
    w_tval = {XLEN{1'b0}};
    if (w_mei) begin
      w_intr = 1'b1;
      w_code = 5'd11;
    end else if (w_msi) begin
      w_intr = 1'b1;
      w_code = 5'd3;
    end else if (w_mti) begin
      w_intr = 1'b1;
      w_code = 5'd7;
    end else if (|w_lirq) begin
      w_intr = 1'b1;
      w_code = 5'd16 + w_lirq_idx;
    end else if (e_inst_addr_mis_i) begin
      w_code = 5'd0;
      w_tval = pc_i;
    end else if (w_illegal) begin
      w_code = 5'd2;
      w_tval = XLEN'(instruction_i);
    end else if (w_ebreak) begin
      w_code = 5'd3;
      w_tval = pc_i;
    end else if (w_ecall) begin
      w_code = 5'd11;
    end else if (e_ld_addr_mis_i) begin
      w_code = 5'd4;
      w_tval = mem_addr_i;
    end else if (e_st_addr_mis_i) begin
      w_code = 5'd6;
      w_tval = mem_addr_i;
    end else begin
      w_trap = 1'b0;
    end
  end

  assign w_mcause = {w_intr, {(XLEN-6){1'b0}}, w_code};

  // Write-back source selection by opcode
  always_comb begin
    w_wb_en   = 1'b1;
    w_wb_data = {XLEN{1'b0}};
    case (w_opcode)
      OPC_OP, OPC_OPI, OPC_LUI, OPC_AUIPC: w_wb_data = alu_d_i;
      OPC_LOAD:                            w_wb_data = mem_d_i;
      OPC_JAL, OPC_JALR:                   w_wb_data = pc_i + PC_STEP;
      OPC_SYSTEM: begin
        w_wb_en   = (w_funct3 != 3'd0);
        w_wb_data = csr_rdata_i;
      end
      default: w_wb_en = 1'b0;
    endcase
  end

  // FSM state and flush counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_cnt_nxt;
    end
  end

  // Next state and next output values; only RUN looks at the inputs
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_flush_cnt;
    w_rd_nxt      = 5'd0;
    w_wd_nxt      = {XLEN{1'b0}};
    w_we_nxt      = 1'b0;
    w_trap_we_nxt = 1'b0;
    w_mcause_nxt  = {XLEN{1'b0}};
    w_mepc_nxt    = {XLEN{1'b0}};
    w_mtval_nxt   = {XLEN{1'b0}};
    w_mret_nxt    = 1'b0;
    w_redir_nxt   = 1'b0;
    w_rpc_nxt     = {XLEN{1'b0}};
    w_retired_nxt = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (valid_i && w_trap) begin
          w_trap_we_nxt = 1'b1;
          w_mcause_nxt  = w_mcause;
          w_mepc_nxt    = pc_i;
          w_mtval_nxt   = w_tval;
          w_redir_nxt   = 1'b1;
          w_rpc_nxt     = mtvec_i;
          w_state_nxt   = ST_REDIRECT;
        end else if (valid_i && w_mret) begin
          w_mret_nxt    = 1'b1;
          w_redir_nxt   = 1'b1;
          w_rpc_nxt     = mepc_i;
          w_retired_nxt = 1'b1;
          w_state_nxt   = ST_REDIRECT;
        end else if (valid_i) begin
          w_retired_nxt = 1'b1;
          w_rd_nxt      = w_rd;
          w_wd_nxt      = w_wb_data;
          w_we_nxt      = w_wb_en & (w_rd != 5'd0);
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_REDIRECT: begin
        if (FLUSH_CYCLES > 0) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = FLUSH_LOAD;
        end else begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 4'd0;
        end
      end
      ST_FLUSH: begin
        if (r_flush_cnt == 4'd0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_flush_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Registered outputs; ready/flush describe the state entered at this edge
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_o          <= 5'd0;
      rf_wd_o       <= {XLEN{1'b0}};
      we_rf_o       <= 1'b0;
      trap_we_o     <= 1'b0;
      mcause_o      <= {XLEN{1'b0}};
      mepc_o        <= {XLEN{1'b0}};
      mtval_o       <= {XLEN{1'b0}};
      mret_o        <= 1'b0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= {XLEN{1'b0}};
      flush_o       <= 1'b0;
      ready_o       <= 1'b0;
      retired_o     <= 1'b0;
    end else begin
      rd_o          <= w_rd_nxt;
      rf_wd_o       <= w_wd_nxt;
      we_rf_o       <= w_we_nxt;
      trap_we_o     <= w_trap_we_nxt;
      mcause_o      <= w_mcause_nxt;
      mepc_o        <= w_mepc_nxt;
      mtval_o       <= w_mtval_nxt;
      mret_o        <= w_mret_nxt;
      redirect_o    <= w_redir_nxt;
      redirect_pc_o <= w_rpc_nxt;
      flush_o       <= (w_state_nxt != ST_RUN);
      ready_o       <= (w_state_nxt == ST_RUN);
      retired_o     <= w_retired_nxt;
    end
  end

endmodule

// File: tb/tb_wb_trap_unit.sv
// Self-checking bench for wb_trap_unit: directed scenarios followed by random
// traffic, all scored against a behavioural model through expectation queues.
module tb_wb_trap_unit;
  localparam int XLEN = 32;
  localparam int NL   = 4;
  localparam int SS   = 2;
  localparam int FC   = 2;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic valid_i = 1'b0;
  logic [31:0] pc_i = 32'h0, instruction_i = 32'h0;
  logic [31:0] alu_d_i = 32'h0, mem_d_i = 32'h0, csr_rdata_i = 32'h0, mem_addr_i = 32'h0;
  logic [31:0] mtvec_i = 32'h0, mepc_i = 32'h0;
  logic mstatus_mie_i = 1'b0;
  logic [15+NL:0] mie_i = '0;
  logic xint_meip_i = 1'b0, xint_mtip_i = 1'b0, xint_msip_i = 1'b0;
  logic [NL-1:0] lirq_i = '0;
  logic e_illegal_inst_i = 1'b0, e_inst_addr_mis_i = 1'b0, e_ld_addr_mis_i = 1'b0, e_st_addr_mis_i = 1'b0;
  logic [4:0] rd_o;
  logic [31:0] rf_wd_o, mcause_o, mepc_o, mtval_o, redirect_pc_o;
  logic we_rf_o, trap_we_o, mret_o, redirect_o, flush_o, ready_o, retired_o;

  always #5 clk_i = ~clk_i;

  wb_trap_unit #(.XLEN(XLEN), .NUM_LIRQ(NL), .SYNC_STAGES(SS), .FLUSH_CYCLES(FC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i),
    .instruction_i(instruction_i), .alu_d_i(alu_d_i), .mem_d_i(mem_d_i),
    .csr_rdata_i(csr_rdata_i), .mem_addr_i(mem_addr_i), .mtvec_i(mtvec_i),
    .mepc_i(mepc_i), .mstatus_mie_i(mstatus_mie_i), .mie_i(mie_i),
    .xint_meip_i(xint_meip_i), .xint_mtip_i(xint_mtip_i), .xint_msip_i(xint_msip_i),
    .lirq_i(lirq_i), .e_illegal_inst_i(e_illegal_inst_i),
    .e_inst_addr_mis_i(e_inst_addr_mis_i), .e_ld_addr_mis_i(e_ld_addr_mis_i),
    .e_st_addr_mis_i(e_st_addr_mis_i), .rd_o(rd_o), .rf_wd_o(rf_wd_o),
    .we_rf_o(we_rf_o), .trap_we_o(trap_we_o), .mcause_o(mcause_o), .mepc_o(mepc_o),
    .mtval_o(mtval_o), .mret_o(mret_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .flush_o(flush_o), .ready_o(ready_o),
    .retired_o(retired_o)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        trap;
    logic [31:0] mcause;
    logic [31:0] mepc;
    logic [31:0] mtval;
    logic        mret;
    logic        redir;
    logic [31:0] rpc;
    logic        ret;
  } ev_t;

  typedef struct packed {
    logic ready;
    logic flush;
    logic ev;
  } hs_t;

  ev_t q_ev[$];
  hs_t q_hs[$];
  logic [NL+2:0] hist[$];   // interrupt levels seen at past edges, oldest first
  int  busy;                // cycles left in which the unit ignores its inputs
  bit  mon_en = 1'b0;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference behaviour for one accepted instruction; syn = levels synchronised by now
  function automatic ev_t model(input logic [NL+2:0] syn);
    ev_t e = '0;
    int code = -1;
    bit intr = 1'b0;
    logic [31:0] tval = 32'h0;
    logic [6:0] op = instruction_i[6:0];
    logic wb = 1'b0;
    logic [31:0] data = 32'h0;
    if (mstatus_mie_i) begin
      if (syn[0] && mie_i[11]) begin code = 11; intr = 1'b1; end
      else if (syn[1] && mie_i[3]) begin code = 3; intr = 1'b1; end
      else if (syn[2] && mie_i[7]) begin code = 7; intr = 1'b1; end
      else begin
        for (int i = 0; i < NL; i++)
          if (code < 0 && syn[3+i] && mie_i[16+i]) begin code = 16 + i; intr = 1'b1; end
      end
    end
    if (code < 0) begin
      if (e_inst_addr_mis_i) begin code = 0; tval = pc_i; end
      else if (e_illegal_inst_i || instruction_i == 32'h00200073 || instruction_i == 32'h10200073) begin
        code = 2; tval = instruction_i;
      end
      else if (instruction_i == 32'h00100073) begin code = 3; tval = pc_i; end
      else if (instruction_i == 32'h00000073) code = 11;
      else if (e_ld_addr_mis_i) begin code = 4; tval = mem_addr_i; end
      else if (e_st_addr_mis_i) begin code = 6; tval = mem_addr_i; end
    end
    if (code >= 0) begin
      e.trap = 1'b1;
      e.mcause = (intr ? 32'h8000_0000 : 32'h0) + 32'(code);
      e.mepc = pc_i;
      e.mtval = tval;
      e.redir = 1'b1;
      e.rpc = mtvec_i;
    end else if (instruction_i == 32'h30200073) begin
      e.mret = 1'b1; e.redir = 1'b1; e.rpc = mepc_i; e.ret = 1'b1;
    end else begin
      e.ret = 1'b1;
      if (op == 7'h33 || op == 7'h13 || op == 7'h37 || op == 7'h17) begin wb = 1'b1; data = alu_d_i; end
      else if (op == 7'h03) begin wb = 1'b1; data = mem_d_i; end
      else if (op == 7'h6F || op == 7'h67) begin wb = 1'b1; data = pc_i + 32'd4; end
      else if (op == 7'h73 && instruction_i[14:12] != 3'd0) begin wb = 1'b1; data = csr_rdata_i; end
      if (wb && instruction_i[11:7] != 5'd0) begin
        e.we = 1'b1; e.rd = instruction_i[11:7]; e.wd = data;
      end
    end
    return e;
  endfunction

  // Predict the outcome of the coming edge from the current inputs, then take it
  task automatic step();
    logic [NL+2:0] syn;
    ev_t e;
    hs_t h;
    e = '0;
    syn = hist.pop_front();
    hist.push_back({lirq_i, xint_mtip_i, xint_msip_i, xint_meip_i});
    if (busy > 0) busy--;
    else if (valid_i) begin
      e = model(syn);
      if (e.trap || e.mret) busy = 1 + FC;
    end
    h.ready = (busy == 0);
    h.flush = (busy > 0);
    h.ev = (e != '0);
    if (h.ev) q_ev.push_back(e);
    q_hs.push_back(h);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_i = 1'b0;
    #1;
    chk("reset_outputs", 32'({we_rf_o, trap_we_o, mret_o, redirect_o, flush_o, ready_o, retired_o,
        |rd_o, |rf_wd_o, |mcause_o, |mepc_o, |mtval_o, |redirect_pc_o}), 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    q_ev.delete();
    q_hs.delete();
    hist.delete();
    repeat (SS) hist.push_back('0);
    busy = 0;
    valid_i = 1'b0;
    rst_i = 1'b1;
    step();
    mon_en = 1'b1;
    chk("ready_after_reset", 32'(ready_o), 32'h1);
  endtask

  task automatic monitor();
    hs_t h;
    ev_t a, x;
    logic act_ev;
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        act_ev = we_rf_o | retired_o | trap_we_o | mret_o | redirect_o;
        if (q_hs.size() == 0) begin
          errors++;
          $display("FAIL handshake: got output cycle with no expectation queued");
        end else begin
          h = q_hs.pop_front();
          checks++;
          if ({ready_o, flush_o, act_ev} !== {h.ready, h.flush, h.ev}) begin
            errors++;
            $display("FAIL handshake: got ready/flush/event %b%b%b want %b%b%b",
                     ready_o, flush_o, act_ev, h.ready, h.flush, h.ev);
          end
        end
        if (act_ev) begin
          a = '0;
          a.we = we_rf_o; a.ret = retired_o; a.trap = trap_we_o; a.mret = mret_o; a.redir = redirect_o;
          if (we_rf_o) begin a.rd = rd_o; a.wd = rf_wd_o; end
          if (trap_we_o) begin a.mcause = mcause_o; a.mepc = mepc_o; a.mtval = mtval_o; end
          if (redirect_o) a.rpc = redirect_pc_o;
          if (q_ev.size() == 0) begin
            errors++;
            $display("FAIL event: got %h want nothing", a);
          end else begin
            x = q_ev.pop_front();
            checks++;
            if (a !== x) begin
              errors++;
              $display("FAIL event: got %h want %h", a, x);
            end
          end
        end
      end
    end
  endtask

  task automatic random_phase();
    logic [6:0] ops [9];
    logic [31:0] sys [5];
    logic [31:0] r;
    int k;
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h6F, 7'h67, 7'h73, 7'h23};
    sys = '{32'h00000073, 32'h00100073, 32'h30200073, 32'h00200073, 32'h10200073};
    mtvec_i = 32'h0000_0400;
    for (int c = 0; c < 600; c++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      pc_i = $urandom;
      alu_d_i = $urandom; mem_d_i = $urandom; csr_rdata_i = $urandom;
      mem_addr_i = $urandom; mepc_i = $urandom;
      if ($urandom_range(0, 15) == 0) mtvec_i = $urandom;
      k = $urandom_range(0, 10);
      r = $urandom;
      if (k < 9) r[6:0] = ops[k];
      else if (k == 9) r = sys[$urandom_range(0, 4)];
      else r = 32'h30200073;
      instruction_i = r;
      e_illegal_inst_i  = ($urandom_range(0, 15) == 0);
      e_inst_addr_mis_i = ($urandom_range(0, 15) == 0);
      e_ld_addr_mis_i   = ($urandom_range(0, 15) == 0);
      e_st_addr_mis_i   = ($urandom_range(0, 15) == 0);
      mstatus_mie_i = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 19) == 0) mie_i = 20'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        r = $urandom & $urandom & $urandom;
        {lirq_i, xint_mtip_i, xint_msip_i, xint_meip_i} = r[NL+2:0];
      end
      step();
    end
  endtask

  task automatic drive();
    #2;
    do_reset();

    // ADDI x5 and ADDI x0
    pc_i = 32'h10; alu_d_i = 32'h1234; instruction_i = 32'h00100293; valid_i = 1'b1;
    step();
    chk("addi_we", 32'(we_rf_o), 32'h1);
    chk("addi_rd", 32'(rd_o), 32'h5);
    chk("addi_wd", rf_wd_o, 32'h1234);
    chk("addi_ret", 32'(retired_o), 32'h1);
    instruction_i = 32'h00100013;
    step();
    chk("addi_x0_we", 32'(we_rf_o), 32'h0);

    // JAL at the top of the address space wraps the link value
    pc_i = 32'hFFFF_FFFC; instruction_i = 32'h000000EF;
    step();
    chk("jal_wrap_wd", rf_wd_o, 32'h0);
    chk("jal_wrap_we", 32'(we_rf_o), 32'h1);

    // Illegal plus load-misaligned: illegal wins, then the flush window
    pc_i = 32'h40; mem_addr_i = 32'h55; mtvec_i = 32'h100; instruction_i = 32'hDEADBEEF;
    e_illegal_inst_i = 1'b1; e_ld_addr_mis_i = 1'b1;
    step();
    chk("ill_trap_we", 32'(trap_we_o), 32'h1);
    chk("ill_mcause", mcause_o, 32'h2);
    chk("ill_mtval", mtval_o, 32'hDEADBEEF);
    chk("ill_rpc", redirect_pc_o, 32'h100);
    chk("ill_flush", 32'({flush_o, ready_o, we_rf_o}), 32'h4);
    e_illegal_inst_i = 1'b0; e_ld_addr_mis_i = 1'b0; instruction_i = 32'h00100293;
    repeat (2) begin
      step();
      chk("flush_window", 32'({flush_o, ready_o, we_rf_o}), 32'h4);
    end
    step();
    chk("flush_done", 32'({flush_o, ready_o, we_rf_o}), 32'h2);
    idle(1);

    // External interrupt is only seen after the synchroniser delay
    mie_i = 20'h00800; mstatus_mie_i = 1'b1; xint_meip_i = 1'b1; valid_i = 1'b1; pc_i = 32'h80;
    repeat (SS) begin
      step();
      chk("mei_sync_delay", 32'({trap_we_o, retired_o}), 32'h1);
    end
    step();
    chk("mei_mcause", mcause_o, 32'h8000000B);
    chk("mei_mtval", mtval_o, 32'h0);
    chk("mei_mepc", mepc_o, 32'h80);
    chk("mei_no_wb", 32'({we_rf_o, retired_o}), 32'h0);
    xint_meip_i = 1'b0;
    idle(4);

    // Local interrupts: lowest index wins; masked globally they are ignored
    mie_i = 20'h60000; lirq_i = 4'b0110;
    idle(2);
    valid_i = 1'b1; pc_i = 32'h90;
    step();
    chk("lirq_mcause", mcause_o, 32'h80000011);
    idle(4);
    mstatus_mie_i = 1'b0; valid_i = 1'b1;
    step();
    chk("lirq_masked", 32'({trap_we_o, retired_o}), 32'h1);
    lirq_i = 4'b0000; mstatus_mie_i = 1'b1;
    idle(3);

    // MRET, then reset in the middle of the following flush
    mepc_i = 32'h2000; instruction_i = 32'h30200073; valid_i = 1'b1;
    step();
    chk("mret_strobe", 32'({mret_o, redirect_o, trap_we_o}), 32'h6);
    chk("mret_rpc", redirect_pc_o, 32'h2000);
    idle(1);
    do_reset();

    random_phase();
    idle(5);
    @(negedge clk_i);
    #1;
  endtask

  initial begin
    repeat (SS) hist.push_back('0);
    busy = 0;
    fork
      drive();
      monitor();
    join_any
    disable fork;
    chk("queues_drained", 32'(q_ev.size() + q_hs.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_trap_unit.md
Name: wb_trap_unit

Overview:
Parametrised successor to the write-back stage. It performs register-file write-back and encodes prioritised synchronous exceptions plus synchronised external and local interrupts. It issues a registered trap/MRET redirect and runs a counted pipeline-flush sequence. Sits at the end of the pipeline; drives the CSR file trap-write bus and the fetch redirect.

Parameters:
XLEN, 32, datapath/CSR width
NUM_LIRQ, 4, local interrupt lines (mcause 16+i), 0..16
SYNC_STAGES, 2, flops per interrupt synchroniser, >=2
FLUSH_CYCLES, 2, flush cycles after a redirect, 0..15

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
valid_i  in  1  instruction present from MEM stage
pc_i  in  XLEN  instruction PC
instruction_i  in  32  instruction word
alu_d_i, mem_d_i, csr_rdata_i  in  XLEN  write-back sources
mem_addr_i  in  XLEN  load/store effective address
mtvec_i, mepc_i  in  XLEN  CSR file values (mtvec direct mode only)
mstatus_mie_i  in  1  global machine interrupt enable
mie_i  in  16+NUM_LIRQ  per-cause enables (bits 3,7,11,16+i)
xint_meip_i, xint_mtip_i, xint_msip_i  in  1  async interrupt levels
lirq_i  in  NUM_LIRQ  async local interrupt levels
e_illegal_inst_i, e_inst_addr_mis_i, e_ld_addr_mis_i, e_st_addr_mis_i  in  1  exception flags
rd_o  out  5  destination register
rf_wd_o  out  XLEN  write data
we_rf_o  out  1  register-file write enable
trap_we_o  out  1  CSR trap update strobe
mcause_o, mepc_o, mtval_o  out  XLEN  trap CSR data
mret_o  out  1  MRET strobe (CSR file restores MIE)
redirect_o  out  1  fetch redirect pulse
redirect_pc_o  out  XLEN  redirect target
flush_o  out  1  kill younger instructions
ready_o  out  1  0 = upstream must hold
retired_o  out  1  instruction committed

Behaviour:
- Reset (rst_i=0, async): every output 0, FSM=RUN, synchronisers and flush counter 0.
- All outputs are registered. Latency is 1 cycle from valid_i to outputs.
- Interrupt pending = synchronised line & mie_i bit & mstatus_mie_i. Sampled only in RUN with valid_i=1, so interrupts are taken at an instruction boundary.
- Priority, highest first: MEI(11), MSI(3), MTI(7), LIRQ lowest index (16+i), inst_addr_mis(0), illegal(2), EBREAK(3), ECALL(11), ld_mis(4), st_mis(6).
- Interrupt: mcause MSB=1, low bits = cause. Exception: MSB=0.
- mtval: illegal -> instruction_i zero-extended. inst_mis and EBREAK -> pc_i. ld/st_mis -> mem_addr_i. ECALL and interrupts -> 0.
- Trap: mepc_o=pc_i, trap_we_o=1 and redirect_o=1 for one cycle, redirect_pc_o=mtvec_i, we_rf_o=0, retired_o=0.
- MRET (instruction_i==0x30200073) with no higher event: mret_o=1, redirect_o=1, redirect_pc_o=mepc_i, retired_o=1, no RF write.
- URET/SRET encodings raise illegal instruction.
- Write-back sources:
  - OP/OPI/LUI/AUIPC -> alu_d_i
  - LOAD -> mem_d_i
  - JAL/JALR -> pc_i+4, wrapping modulo 2^XLEN
  - SYSTEM with funct3!=0 -> csr_rdata_i
- we_rf_o=1 only if valid_i, the opcode is a write-back opcode, rd!=0, no trap, and FSM=RUN.
- retired_o=1 for any valid non-trapping instruction in RUN.
- FSM:
  - RUN -> REDIRECT on trap or MRET.
  - REDIRECT (1 cycle) -> FLUSH when FLUSH_CYCLES>0, else RUN.
  - FLUSH holds for exactly FLUSH_CYCLES cycles, then RUN.
  - In REDIRECT and FLUSH: flush_o=1, ready_o=0, inputs ignored, no writes, no new traps.
- ready_o=1 in RUN.
- An interrupt arriving during REDIRECT/FLUSH stays pending and is taken on the first valid instruction after returning to RUN.
- Simultaneous interrupt and exception: the interrupt wins; mepc=pc_i, and the instruction re-executes later.
- Several exception flags asserted together: only the highest-priority cause is reported.
- valid_i=0: no write, no trap, outputs strobe 0.
- Reset asserted mid-FLUSH: immediate return to RUN with all outputs 0.

Test Plan:
- ADDI x5 result 0x1234, valid_i=1 -> next cycle we_rf_o=1, rd_o=5, rf_wd_o=0x1234, retired_o=1. Same with rd=0 -> we_rf_o=0.
- JAL at pc_i=0xFFFFFFFC -> rf_wd_o=0x00000000 (wrap), we_rf_o=1.
- e_illegal_inst_i and e_ld_addr_mis_i together, instruction 0xDEADBEEF, mtvec_i=0x100 -> trap_we_o=1, mcause_o=2, mtval_o=0xDEADBEEF, redirect_pc_o=0x100. Then flush_o=1 and ready_o=0 for 3 cycles (1+FLUSH_CYCLES), and we_rf_o=0.
- xint_meip_i raised, mie_i[11]=1, mstatus_mie_i=1 -> no trap before SYNC_STAGES cycles. Then on the next valid instruction: mcause_o=0x8000000B, mtval_o=0, mepc_o=pc_i, no write-back.
- lirq_i=4'b0110 with mie_i bits 17,18 set -> mcause_o=0x80000011. Same with mstatus_mie_i=0 -> no trap.
- MRET with mepc_i=0x2000 -> mret_o=1, redirect_pc_o=0x2000, trap_we_o=0. rst_i low during the following FLUSH -> all outputs 0 immediately, ready_o=1 after release.
